// File: rtl/encoder_42.sv
// Registered 4-to-2 priority encoder with valid and multi-request flags.
// Latency: one clk cycle from the capturing edge (en=1) to the outputs.
// Backpressure: none; en=0 freezes every output and ignores the requests.
module encoder_42 #(
    parameter bit HIGH_WINS    = 1'b1,
    parameter bit HOLD_ON_IDLE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic i4,
    output logic o0,
    output logic o1,
    output logic valid,
    output logic multi
);

    logic [3:0] req;
    logic [1:0] code_nxt;
    logic       any_nxt;
    logic       multi_nxt;
    logic [2:0] req_cnt;

    logic [1:0] code_q;
    logic       valid_q;
    logic       multi_q;

    assign req = {i4, i3, i2, i1};

    always_comb begin
        code_nxt = 2'b00;
        if (HIGH_WINS) begin
            if (req[3])      code_nxt = 2'b11;
            else if (req[2]) code_nxt = 2'b10;
            else if (req[1]) code_nxt = 2'b01;
            else             code_nxt = 2'b00;
        end else begin
            if (req[0])      code_nxt = 2'b00;
            else if (req[1]) code_nxt = 2'b01;
            else if (req[2]) code_nxt = 2'b10;
            else if (req[3]) code_nxt = 2'b11;
            else             code_nxt = 2'b00;
        end
    end

    always_comb begin
        req_cnt   = {2'b00, req[0]} + {2'b00, req[1]} + {2'b00, req[2]} + {2'b00, req[3]};
        any_nxt   = |req;
        multi_nxt = (req_cnt >= 3'd2);
    end

    // Idle with HOLD_ON_IDLE keeps the last winning index; otherwise the code follows code_nxt (00 when idle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= 2'b00;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else if (en) begin
            valid_q <= any_nxt;
            multi_q <= multi_nxt;
            if (any_nxt || !HOLD_ON_IDLE) begin
                code_q <= code_nxt;
            end
        end
    end

    assign o0    = code_q[0];
    assign o1    = code_q[1];
    assign valid = valid_q;
    assign multi = multi_q;

endmodule

// File: tb/tb_encoder_42.sv
// Directed bench for encoder_42: three instances cover high/low priority and idle-hold variants.
module tb_encoder_42;

    logic clk;
    logic rst_n;
    logic en;
    logic i1, i2, i3, i4;

    logic hw_o0, hw_o1, hw_valid, hw_multi;
    logic lw_o0, lw_o1, lw_valid, lw_multi;
    logic hd_o0, hd_o1, hd_valid, hd_multi;

    int nvec;
    int errs;

    encoder_42 #(.HIGH_WINS(1'b1), .HOLD_ON_IDLE(1'b0)) u_hw (
        .clk(clk), .rst_n(rst_n), .en(en),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4),
        .o0(hw_o0), .o1(hw_o1), .valid(hw_valid), .multi(hw_multi)
    );

    encoder_42 #(.HIGH_WINS(1'b0), .HOLD_ON_IDLE(1'b0)) u_lw (
        .clk(clk), .rst_n(rst_n), .en(en),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4),
        .o0(lw_o0), .o1(lw_o1), .valid(lw_valid), .multi(lw_multi)
    );

    encoder_42 #(.HIGH_WINS(1'b1), .HOLD_ON_IDLE(1'b1)) u_hd (
        .clk(clk), .rst_n(rst_n), .en(en),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4),
        .o0(hd_o0), .o1(hd_o1), .valid(hd_valid), .multi(hd_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vectors are packed as {o1, o0, valid, multi}.
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nvec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        {i4, i3, i2, i1} = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  hw_code_tab [16];
    logic [1:0]  lw_code_tab [16];
    logic [15:0] multi_mask;
    logic [3:0]  pat;
    logic        vld;

    initial begin
        nvec = 0;
        errs = 0;
        hw_code_tab = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
                        2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
        lw_code_tab = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00,
                        2'b11, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        multi_mask  = 16'b1111_1110_1110_1000;

        rst_n = 1'b0;
        en    = 1'b1;
        drive(4'b0000);
        #2;
        chk("reset_state", {hw_o1, hw_o0, hw_valid, hw_multi}, 4'b0000);
        step();
        rst_n = 1'b1;

        drive(4'b1111);
        step();
        chk("pre_reset_capture", {hw_o1, hw_o0, hw_valid, hw_multi}, 4'b1111);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_hw", {hw_o1, hw_o0, hw_valid, hw_multi}, 4'b0000);
        chk("async_reset_hd", {hd_o1, hd_o0, hd_valid, hd_multi}, 4'b0000);
        step();
        chk("reset_held", {hw_o1, hw_o0, hw_valid, hw_multi}, 4'b0000);
        rst_n = 1'b1;
        #2;
        chk("release_no_edge", {hw_o1, hw_o0, hw_valid, hw_multi}, 4'b0000);
        step();
        chk("post_release_capture", {hw_o1, hw_o0, hw_valid, hw_multi}, 4'b1111);

        for (int v = 0; v < 16; v++) begin
            pat = v[3:0];
            drive(pat);
            step();
            vld = (pat != 4'b0000);
            chk($sformatf("sweep_hw_%b", pat), {hw_o1, hw_o0, hw_valid, hw_multi},
                {hw_code_tab[v], vld, multi_mask[v]});
            chk($sformatf("sweep_lw_%b", pat), {lw_o1, lw_o0, lw_valid, lw_multi},
                {lw_code_tab[v], vld, multi_mask[v]});
        end

        drive(4'b1010);
        step();
        chk("lw_1010", {lw_o1, lw_o0, lw_valid, lw_multi}, 4'b0111);
        drive(4'b1100);
        step();
        chk("lw_1100", {lw_o1, lw_o0, lw_valid, lw_multi}, 4'b1011);
        drive(4'b1000);
        step();
        chk("lw_1000", {lw_o1, lw_o0, lw_valid, lw_multi}, 4'b1110);

        drive(4'b0100);
        step();
        chk("hold_set_hd", {hd_o1, hd_o0, hd_valid, hd_multi}, 4'b1010);
        chk("hold_set_hw", {hw_o1, hw_o0, hw_valid, hw_multi}, 4'b1010);
        drive(4'b0000);
        step();
        chk("hold_idle_hd", {hd_o1, hd_o0, hd_valid, hd_multi}, 4'b1000);
        chk("hold_idle_hw", {hw_o1, hw_o0, hw_valid, hw_multi}, 4'b0000);

        drive(4'b1000);
        step();
        chk("en_capture", {hw_o1, hw_o0, hw_valid, hw_multi}, 4'b1110);
        en = 1'b0;
        drive(4'b0001);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("en_low_hold_%0d", k), {hw_o1, hw_o0, hw_valid, hw_multi}, 4'b1110);
        end
        chk("en_low_hold_hd", {hd_o1, hd_o0, hd_valid, hd_multi}, 4'b1110);
        en = 1'b1;
        step();
        chk("en_resume", {hw_o1, hw_o0, hw_valid, hw_multi}, 4'b0010);

        drive(4'b0000);
        step();
        chk("glitch_base", {hw_o1, hw_o0, hw_valid, hw_multi}, 4'b0000);
        drive(4'b1111);
        #1;
        chk("glitch_1111", {hw_o1, hw_o0, hw_valid, hw_multi}, 4'b0000);
        drive(4'b0101);
        #1;
        chk("glitch_0101", {hw_o1, hw_o0, hw_valid, hw_multi}, 4'b0000);
        drive(4'b1000);
        #1;
        drive(4'b0010);
        #1;
        chk("glitch_settled", {hw_o1, hw_o0, hw_valid, hw_multi}, 4'b0000);
        step();
        chk("glitch_edge", {hw_o1, hw_o0, hw_valid, hw_multi}, 4'b0110);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule

// File: doc/encoder_42.md
Name: encoder_42

Overview:
- Registered 4-to-2 priority encoder.
- Four one-bit request inputs i1..i4 are encoded into a 2-bit index {o1,o0}, plus a valid flag.
- Sits at the boundary between request/flag logic and downstream index consumers (mux selects, arbiter grants).
- Outputs are registered on clk, so downstream logic sees glitch-free, cycle-aligned codes.

Parameters:
- HIGH_WINS, default 1: priority direction. 1 = highest-numbered active input wins (i4 > i3 > i2 > i1). 0 = lowest-numbered wins (i1 > i2 > i3 > i4).
- HOLD_ON_IDLE, default 0: behaviour when no input is active. 0 = code forced to 00. 1 = code holds its last valid value. valid deasserts in both cases.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  capture enable; when low, all outputs hold.
- i1  input  1  request 1; encodes to 00.
- i2  input  1  request 2; encodes to 01.
- i3  input  1  request 3; encodes to 10.
- i4  input  1  request 4; encodes to 11.
- o0  output  1  index LSB (registered).
- o1  output  1  index MSB (registered).
- valid  output  1  high when at least one input was active at the last capture (registered).
- multi  output  1  high when two or more inputs were active at the last capture (registered).

Behaviour:
- Reset:
  - rst_n low immediately forces o0=0, o1=0, valid=0, multi=0, regardless of clk.
  - Outputs stay at these values while rst_n is low.
  - Release is sampled at the next rising clk edge: the first capture occurs on the first rising edge with rst_n high and en high.
- Encoding, combinational before the register; index = {o1,o0}:
  - Winner i1 -> 00; i2 -> 01; i3 -> 10; i4 -> 11.
  - HIGH_WINS=1: i4 active -> 11; else i3 -> 10; else i2 -> 01; else i1 -> 00.
  - HIGH_WINS=0: i1 active -> 00; else i2 -> 01; else i3 -> 10; else i4 -> 11.
- Idle (all inputs 0):
  - valid=0, multi=0.
  - Code = 00 if HOLD_ON_IDLE=0; otherwise the previous code is retained.
  - Code 00 with valid=1 means "i1 won"; code 00 with valid=0 means "no request". Consumers must qualify the code with valid.
- multi = 1 iff popcount(i1..i4) >= 2, computed on the same sample as the code.
- Latency: exactly one clk cycle from inputs to outputs. The sample is taken at the rising edge with en=1; outputs change only at that edge (or at async reset).
- en=0: the register holds all outputs (o0, o1, valid, multi) unchanged; the inputs are ignored.
- Inputs may change any number of times between edges. Only values at the capturing edge matter; no intermediate glitches reach the outputs.
- X/Z on inputs is not a supported operating condition. Inputs not driven by the instantiating level must be tied to 0 (e.g. i4 unused => tie low).
- No other state; no handshake beyond en.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with inputs 1111 -> o1,o0,valid,multi go 0,0,0,0 immediately, without waiting for a clk edge; stay 0 until a capture after release.
- Exhaustive sweep, HIGH_WINS=1, en=1: drive {i4,i3,i2,i1} = 0000..1111, one per cycle; check each one cycle later:
  - 0000 -> code 00, valid 0.
  - 0001 -> 00, valid 1.
  - 0010/0011 -> 01.
  - 01xx -> 10.
  - 1xxx -> 11, valid 1.
  - multi=1 exactly for 0011, 0101, 0110, 0111 and all 1xxx except 1000.
- Priority direction: HIGH_WINS=0, input 1010 -> code 01; input 1100 -> code 10; input 1000 -> code 11, multi 0.
- Idle hold: HOLD_ON_IDLE=1; drive 0100 (code 10, valid 1), then 0000 -> code stays 10, valid 0. With HOLD_ON_IDLE=0 the same sequence gives code 00, valid 0.
- Enable gating: capture 1000 (code 11); set en=0 and drive 0001 for 3 cycles -> outputs stay 11/valid 1; raise en -> code 00 one cycle later.
- Single-edge sampling: toggle inputs between edges, settling to 0010 before the edge -> output 01 only after the edge, with no intermediate output change.
